// File: rtl/router_pkg.sv
// router_pkg: shared sizing and header-length field position for the router FIFO.
package router_pkg;
  localparam int DEPTH = 16;
  localparam int DWIDTH = 8;
  localparam int LEN_LO = 2;
endpackage

// File: rtl/router_fifo_ptr.sv
// router_fifo_ptr: wrap-bit pointer register, cleared synchronously and advanced by inc.
module router_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [AW:0] ptr
);
  always_ff @(posedge clk)
    ptr <= rst ? '0 : ptr + (AW+1)'(inc);
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-port packet FIFO storing a header flag per byte and tracking unread packet bytes.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = router_pkg::DEPTH,
  parameter int DWIDTH = router_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DWIDTH - LEN_LO + 1;
  logic [DWIDTH:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] pkt_cnt;
  logic [DWIDTH:0] rd_ent;
  logic clr, do_wr, do_rd;
  assign clr = rst | soft_reset;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = write_enb & ~full & ~clr;
  assign do_rd = read_enb & ~empty & ~clr;
  assign rd_ent = mem[rd_ptr[AW-1:0]];
  assign pkt_busy = pkt_cnt != '0;
  router_fifo_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(clr), .inc(do_wr), .ptr(wr_ptr));
  router_fifo_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(clr), .inc(do_rd), .ptr(rd_ptr));
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  // a header reload counts payload bytes plus the trailing parity byte
  always_ff @(posedge clk) begin
    if (clr) begin
      data_out <= '0;
      pkt_cnt <= '0;
    end else if (do_rd) begin
      data_out <= rd_ent[DWIDTH-1:0];
      pkt_cnt <= rd_ent[DWIDTH] ? CW'(rd_ent[DWIDTH-1:LEN_LO]) + CW'(1) : pkt_cnt - CW'(pkt_busy);
    end
  end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: randomized bench comparing router_fifo against a queue-based packet FIFO model.
module tb_router_fifo;
  logic clk = 0, rst = 1, soft_reset = 0, write_enb = 0, read_enb = 0, lfd_state = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic full, empty, pkt_busy;
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  logic [7:0] e_dout = 0;
  int e_cnt = 0;

  router_fifo dut (
    .clk(clk), .rst(rst), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .pkt_busy(pkt_busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic w, input logic r, input logic l, input logic [7:0] d,
                      input logic sr, input logic rs);
    logic [8:0] e;
    bit rd, wr;
    write_enb = w; read_enb = r; lfd_state = l; data_in = d; soft_reset = sr; rst = rs;
    if (rs || sr) begin
      q.delete();
      e_dout = 0;
      e_cnt = 0;
    end else begin
      rd = r && q.size() != 0;
      wr = w && q.size() != 16;
      if (rd) begin
        e = q.pop_front();
        e_dout = e[7:0];
        e_cnt = e[8] ? int'(e[7:2]) + 1 : (e_cnt > 0 ? e_cnt - 1 : 0);
      end
      if (wr) q.push_back({l, d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({data_out, empty, full, pkt_busy} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset dout=%h empty=%b full=%b busy=%b want 00 1 0 0", data_out, empty, full, pkt_busy);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fill();
    logic [4:0] wp;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'($urandom), 0, 0);
      checks++;
      if (full !== (i == 15) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill%0d full=%b empty=%b want %b 0", i, full, empty, i == 15);
      end
    end
    wp = dut.wr_ptr;
    step(1, 0, 0, 8'hAA, 0, 0);
    checks++;
    if (dut.wr_ptr !== wp || full !== 1'b1 || q.size() != 16) begin
      errors++;
      $display("FAIL overflow wr_ptr=%h want %h full=%b want 1", dut.wr_ptr, wp, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (data_out !== e_dout || empty !== (i == 15) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain%0d dout=%h want %h empty=%b want %b", i, data_out, e_dout, empty, i == 15);
      end
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (data_out !== e_dout || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow dout=%h want %h empty=%b", data_out, e_dout, empty);
    end
  endtask

  task automatic test_packet();
    step(1, 0, 1, 8'h0C, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if (int'(dut.pkt_cnt) != 4 - i || pkt_busy !== (i != 4) || data_out !== e_dout) begin
        errors++;
        $display("FAIL packet%0d cnt=%0d want %0d busy=%b dout=%h want %h", i, dut.pkt_cnt, 4 - i, pkt_busy, data_out, e_dout);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 8'($urandom), 0, 0);
      checks++;
      if (data_out !== e_dout || empty !== 1'b0 || full !== 1'b0 || 5'(dut.wr_ptr - dut.rd_ptr) !== 5'd5) begin
        errors++;
        $display("FAIL stream%0d dout=%h want %h occ=%0d want 5", i, data_out, e_dout, 5'(dut.wr_ptr - dut.rd_ptr));
      end
    end
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    checks++;
    if (data_out !== e_dout || empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_tail dout=%h want %h empty=%b", data_out, e_dout, empty);
    end
  endtask

  task automatic test_soft_reset();
    step(1, 0, 1, 8'h20, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 8'($urandom), 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (pkt_busy !== 1'b1 || int'(dut.pkt_cnt) != 8 || q.size() != 7) begin
      errors++;
      $display("FAIL pre_soft busy=%b cnt=%0d want 1 8", pkt_busy, dut.pkt_cnt);
    end
    step(1, 1, 0, 8'h55, 1, 0);
    checks++;
    if ({data_out, empty, full, pkt_busy} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL soft_reset dout=%h empty=%b full=%b busy=%b want 00 1 0 0", data_out, empty, full, pkt_busy);
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      errors++;
      $display("FAIL soft_lost dout=%h empty=%b want 00 1", data_out, empty);
    end
  endtask

  task automatic test_hard_reset();
    step(1, 0, 1, 8'hFC, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 8'($urandom), 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 8'h11, 0, 0);
    checks++;
    if (full !== 1'b1 || pkt_busy !== 1'b1) begin
      errors++;
      $display("FAIL prefull full=%b busy=%b want 1 1", full, pkt_busy);
    end
    step(1, 1, 0, 8'h77, 1, 1);
    checks++;
    if ({data_out, empty, full, pkt_busy} !== {8'h00, 1'b1, 1'b0, 1'b0} || dut.rd_ptr !== 5'd0) begin
      errors++;
      $display("FAIL hard_reset dout=%h empty=%b full=%b busy=%b rd_ptr=%h want 00 1 0 0 00", data_out, empty, full, pkt_busy, dut.rd_ptr);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 4) == 0,
           8'($urandom), $urandom_range(0, 59) == 0, 0);
      checks++;
      if ({data_out, empty, full, pkt_busy} !== {e_dout, q.size() == 0, q.size() == 16, e_cnt != 0} ||
          int'(dut.pkt_cnt) != e_cnt) begin
        errors++;
        $display("FAIL random%0d dout=%h/%h empty=%b full=%b busy=%b cnt=%0d want cnt=%0d occ=%0d",
                 i, data_out, e_dout, empty, full, pkt_busy, dut.pkt_cnt, e_cnt, q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_packet();
    test_stream();
    test_soft_reset();
    test_hard_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of storage entries (power of two).
REQ-003 Parameter DWIDTH, default 8, SHALL set the byte width of the data path.
REQ-004 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 soft_reset  input  1  SHALL be the synchronous flush from the synchronizer timeout.
REQ-007 write_enb  input  1  SHALL be this FIFO's write-select bit from the synchronizer.
REQ-008 read_enb  input  1  SHALL be the read request from the destination port.
REQ-009 lfd_state  input  1  SHALL mark the current write byte as a packet header.
REQ-010 data_in  input  DWIDTH  SHALL be the write byte.
REQ-011 data_out  output  DWIDTH  SHALL be the registered read byte.
REQ-012 full  output  1  SHALL be high when all DEPTH entries are occupied.
REQ-013 empty  output  1  SHALL be high when no entry is occupied.
REQ-014 pkt_busy  output  1  SHALL be high while unread bytes of the current packet remain.

Function
REQ-015 Each entry SHALL store DWIDTH+1 bits: data_in plus lfd_state as the header flag.
REQ-016 Pointers SHALL be log2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
REQ-017 empty SHALL be asserted when wr_ptr equals rd_ptr.
REQ-018 full SHALL be asserted when the MSBs differ and the lower bits are equal.
REQ-019 Both flags SHALL be combinational from the registered pointers, with no extra latency.
REQ-020 A write SHALL occur when write_enb is high and full is low; the pointer advances by one.
REQ-021 A write while full SHALL be dropped, including when a read occurs in the same cycle.
REQ-022 A read SHALL occur when read_enb is high and empty is low; data_out updates on the same edge (1-cycle latency).
REQ-023 A read while empty SHALL be ignored, and data_out SHALL hold its value.
REQ-024 A simultaneous read and write when neither full nor empty SHALL both proceed, with occupancy unchanged.
REQ-025 When the stored header flag of a read entry is 1, pkt_cnt SHALL load data[DWIDTH-1:2]+1 (payload plus parity byte).
REQ-026 Each subsequent read of a non-header entry SHALL decrement pkt_cnt while it is nonzero; pkt_cnt SHALL saturate at 0.
REQ-027 pkt_busy SHALL equal (pkt_cnt != 0).
REQ-028 A header read while pkt_cnt is nonzero SHALL reload pkt_cnt, with no error flag.
REQ-029 Pointers SHALL wrap modulo 2*DEPTH, with no discontinuity at the wrap boundary.

Reset
REQ-030 rst SHALL take priority over soft_reset, and soft_reset SHALL take priority over reads and writes.
REQ-031 On rst or soft_reset: pointers=0, pkt_cnt=0, data_out=0, empty=1, full=0, pkt_busy=0.
REQ-032 Memory contents SHALL NOT require clearing; a write in a soft_reset cycle SHALL be discarded.
REQ-033 A reset asserted mid-packet SHALL abandon the packet, with no residual pkt_busy.

Structure
REQ-034 DEPTH, DWIDTH and the header length-field slice SHALL live in shared package router_pkg.
REQ-035 The wrap-bit pointer register SHALL be one sub-module, router_fifo_ptr, instantiated for read and write.
REQ-036 Storage SHALL be an inferred register array with no tri-state outputs.

Verification
REQ-037 Write 16 bytes with no read -> full=1 after the 16th edge; a 17th write is dropped and wr_ptr is unchanged.
REQ-038 Fill, then read 16 -> bytes return in order, one cycle after each read_enb; empty=1 after the last read.
REQ-039 Header 8'h0C (lfd=1) + 3 payload + parity, then read all -> pkt_cnt goes 4,3,2,1,0; pkt_busy falls after the parity read.
REQ-040 Occupancy 5, read+write together for 40 cycles -> occupancy stays 5, pointers wrap, data order is preserved.
REQ-041 soft_reset pulse mid-packet with occupancy 7 -> next cycle empty=1, data_out=0, pkt_busy=0; the concurrent write is lost.
REQ-042 rst and soft_reset together during a full FIFO -> reset values per REQ-031, with no spurious read.
